alu_exec_unit: RTL and testbench

- Execute-stage ALU. Consumes the 4-bit ALU selection produced by the ALU control unit, plus the two operands and the destination register.
- Returns a registered result over a valid/ready handshake.
- Logic/arithmetic/compare ops complete in 1 cycle.
- Shifts use an iterative 1-bit/cycle shifter, which keeps the barrel shifter off the EX critical path.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_shift_iter.sv | 64 ++++++
 rtl/alu_exec_unit.sv | 178 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: selection codes, FSM
// encoding, shift kinds and default widths. The ALU control unit uses
// the same ALU_* codes so both sides agree on the encoding.
package alu_pkg;

    localparam int DEFAULT_XLEN    = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    // ALU selection codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    typedef enum logic [1:0] {
        SHK_SRL = 2'd0,
        SHK_SLL = 2'd1,
        SHK_SRA = 2'd2
    } shift_kind_e;

    function automatic logic is_shift_sel(input logic [3:0] sel);
        case (sel)
            ALU_SRL, ALU_SLL, ALU_SRA: is_shift_sel = 1'b1;
            default:                   is_shift_sel = 1'b0;
        endcase
    endfunction

    function automatic shift_kind_e shift_kind_of(input logic [3:0] sel);
        case (sel)
            ALU_SLL: shift_kind_of = SHK_SLL;
            ALU_SRA: shift_kind_of = SHK_SRA;
            default: shift_kind_of = SHK_SRL;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 1-bit-per-cycle shifter. A start pulse latches the operand,
// amount and kind; each following cycle shifts once and decrements the
// counter. 'last' flags the cycle whose edge completes the shift, and
// data_next then carries the final value to be captured by the owner.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  shift_kind_e        kind_in,
    input  logic [XLEN-1:0]    data_in,
    input  logic [SHAMT_W-1:0] amount,
    output logic               last,
    output logic [XLEN-1:0]    data_next
);

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]    shreg_r;
    logic [SHAMT_W-1:0] cnt_r;
    shift_kind_e        kind_r;
    logic [XLEN-1:0]    data_next_s;

    // One-bit shift of the working register according to the latched kind
    always_comb begin
        data_next_s = shreg_r;
        case (kind_r)
            SHK_SRL: data_next_s = {1'b0, shreg_r[XLEN-1:1]};
            SHK_SLL: data_next_s = {shreg_r[XLEN-2:0], 1'b0};
            SHK_SRA: data_next_s = {shreg_r[XLEN-1], shreg_r[XLEN-1:1]};
            default: data_next_s = shreg_r;
        endcase
    end

    // Working register, remaining-count and kind; flush abandons the shift
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= {XLEN{1'b0}};
            cnt_r   <= CNT_ZERO;
            kind_r  <= SHK_SRL;
        end else if (flush) begin
            cnt_r   <= CNT_ZERO;
        end else if (start) begin
            shreg_r <= data_in;
            cnt_r   <= amount;
            kind_r  <= kind_in;
        end else if (cnt_r != CNT_ZERO) begin
            shreg_r <= data_next_s;
            cnt_r   <= cnt_r - CNT_ONE;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign last      = (cnt_r == CNT_ONE);
    assign data_next = data_next_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Logic, arithmetic and compare ops produce a registered result one
// cycle after accept; non-zero shifts go through the iterative shifter
// and complete N cycles after accept. Flush drops any in-flight work.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            zero,
    output logic            illegal_op
);

    alu_state_e         state_r;
    alu_state_e         state_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               start_shift_s;
    logic               load_direct_s;
    logic               shift_last_s;
    logic               shift_done_s;
    logic [XLEN-1:0]    shift_data_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [XLEN-1:0]    alu_res_s;
    logic               illegal_s;

    logic [XLEN-1:0]    result_r;
    logic [4:0]         rd_r;
    logic [4:0]         shift_rd_r;
    logic               illegal_r;
    logic               out_valid_r;

    assign shamt_s       = op_b[SHAMT_W-1:0];
    assign accept_s      = in_valid && in_ready_s;
    assign start_shift_s = accept_s && is_shift_sel(alu_sel) && (shamt_s != {SHAMT_W{1'b0}});
    assign load_direct_s = accept_s && !start_shift_s;
    assign shift_done_s  = (state_r == ST_SHIFT) && shift_last_s;

    // Single-cycle datapath; shift codes here only ever see shamt == 0
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        illegal_s = 1'b0;
        case (alu_sel)
            ALU_ADD:  alu_res_s = op_a + op_b;
            ALU_SUB:  alu_res_s = op_a - op_b;
            ALU_PASS: alu_res_s = op_b;
            ALU_OR:   alu_res_s = op_a | op_b;
            ALU_AND:  alu_res_s = op_a & op_b;
            ALU_XOR:  alu_res_s = op_a ^ op_b;
            ALU_SRL:  alu_res_s = op_a;
            ALU_SLL:  alu_res_s = op_a;
            ALU_SRA:  alu_res_s = op_a;
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: begin
                alu_res_s = {XLEN{1'b0}};
                illegal_s = 1'b1;
            end
        endcase
    end

    alu_shift_iter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start_shift_s),
        .kind_in   (shift_kind_of(alu_sel)),
        .data_in   (op_a),
        .amount    (shamt_s),
        .last      (shift_last_s),
        .data_next (shift_data_s)
    );

    // FSM state register; flush returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: enter SHIFT on a non-zero shift, leave on its last step
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_shift_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle, not flushing and the output slot frees
    always_comb begin
        in_ready_s = 1'b0;
        if ((state_r == ST_IDLE) && !flush && (!out_valid_r || out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Destination tag captured at shift start, released when the shift ends
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_rd_r <= 5'd0;
        end else if (start_shift_s) begin
            shift_rd_r <= rd_in;
        end else begin
            shift_rd_r <= shift_rd_r;
        end
    end

    // Output register: load on direct accept or shift completion, else hold/consume
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            rd_r        <= 5'd0;
            illegal_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_direct_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            rd_r        <= rd_in;
            illegal_r   <= illegal_s;
        end else if (shift_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= shift_data_s;
            rd_r        <= shift_rd_r;
            illegal_r   <= 1'b0;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign result     = result_r;
    assign rd_out     = rd_r;
    assign illegal_op = illegal_r;
    assign zero       = (result_r == {XLEN{1'b0}});

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios with literal expectations,
// then randomized traffic, all compared cycle by cycle against a
// transaction-level model (result computed in one step, shifts modelled
// only as a latency countdown).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic        zero, illegal_op;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_in, rd_out;

    int checks = 0;
    int errors = 0;

    // model state
    logic        mv;
    logic [31:0] mres;
    logic [4:0]  mrd;
    logic        mill;
    int          busy;
    logic [31:0] pres;
    logic [4:0]  prd;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_sel    (alu_sel),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd_in      (rd_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .rd_out     (rd_out),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic signed [31:0] sa;
        sh = int'(b[4:0]);
        sa = a;
        case (sel)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return b;
            4'b0100: return a | b;
            4'b0101: return a & b;
            4'b0111: return a ^ b;
            4'b1000: return a >> sh;
            4'b1001: return a << sh;
            4'b1010: return sa >>> sh;
            4'b1101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] sel);
        return !(sel == 4'b0010 || sel == 4'b0110 || sel == 4'b1011 ||
                 sel == 4'b1100 || sel == 4'b1110);
    endfunction

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == 4'b1000 || sel == 4'b1001 || sel == 4'b1010);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven (we sit at negedge).
    task automatic tick();
        logic exp_ready;
        logic acc;
        #1;
        exp_ready = !flush && (busy == 0) && (!mv || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = in_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            mv = 1'b0; mres = 32'd0; mrd = 5'd0; mill = 1'b0; busy = 0;
        end else if (flush) begin
            mv = 1'b0; busy = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                mv = 1'b1; mres = pres; mrd = prd; mill = 1'b0;
            end
        end else begin
            if (mv && out_ready) mv = 1'b0;
            if (acc) begin
                if (is_shift(alu_sel) && op_b[4:0] != 5'd0) begin
                    busy = int'(op_b[4:0]);
                    pres = ref_alu(alu_sel, op_a, op_b);
                    prd  = rd_in;
                end else begin
                    mv   = 1'b1;
                    mres = ref_alu(alu_sel, op_a, op_b);
                    mrd  = rd_in;
                    mill = !is_legal(alu_sel);
                end
            end
        end
        #1;
        chk("out_valid",  {31'd0, out_valid},  {31'd0, mv});
        chk("result",     result,              mres);
        chk("rd_out",     {27'd0, rd_out},     {27'd0, mrd});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, mill});
        chk("zero",       {31'd0, zero},       {31'd0, (mres == 32'd0)});
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1;
        alu_sel  = sel;
        op_a     = a;
        op_b     = b;
        rd_in    = rd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_sel = 4'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        mv = 1'b0; mres = 32'd0; mrd = 5'd0; mill = 1'b0; busy = 0;
        pres = 32'd0; prd = 5'd0;
        @(negedge clk);
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // ADD then back-to-back SUB
        drive(4'b0000, 32'd7, 32'd5, 5'd3);
        tick();
        chk("add_result", result, 32'd12);
        chk("add_zero", {31'd0, zero}, 32'd0);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        drive(4'b0001, 32'd5, 32'd5, 5'd4);
        #1 chk("sub_no_bubble", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sub_result", result, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);

        // compares and pass
        drive(4'b1101, 32'hFFFF_FFFF, 32'd1, 5'd5);
        tick();
        chk("slt_result", result, 32'd1);
        drive(4'b1111, 32'hFFFF_FFFF, 32'd1, 5'd5);
        tick();
        chk("sltu_result", result, 32'd0);
        drive(4'b0011, 32'd0, 32'hDEAD_BEEF, 5'd6);
        tick();
        chk("pass_result", result, 32'hDEAD_BEEF);

        // SRA by 4: four cycles not ready, then result
        drive(4'b1010, 32'h8000_0000, 32'd4, 5'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("sra_busy_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        chk("sra_result", result, 32'hF800_0000);
        chk("sra_rd", {27'd0, rd_out}, 32'd7);
        drive(4'b1000, 32'h8000_0000, 32'd4, 5'd8);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("srl_result", result, 32'h0800_0000);
        drive(4'b1001, 32'd1, 32'd0, 5'd8);
        tick();
        chk("sll0_result", result, 32'd1);
        chk("sll0_valid", {31'd0, out_valid}, 32'd1);

        // backpressure
        drive(4'b0000, 32'd1, 32'd2, 5'd9);
        tick();
        out_ready = 1'b0;
        drive(4'b0111, 32'h0000_00F0, 32'h0000_000F, 5'd10);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_result", result, 32'd3);
            chk("bp_rd", {27'd0, rd_out}, 32'd9);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_new_result", result, 32'h0000_00FF);
        chk("bp_new_rd", {27'd0, rd_out}, 32'd10);

        // SLL by 31, flushed on the 10th shift cycle
        drive(4'b1001, 32'd1, 32'd31, 5'd11);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        #1 chk("flush_ready_after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 25; i++) tick();
        chk("flush_never_valid", {31'd0, out_valid}, 32'd0);

        // same with reset
        drive(4'b1001, 32'd1, 32'd31, 5'd12);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_rd", {27'd0, rd_out}, 32'd0);
        chk("rstmid_zero", {31'd0, zero}, 32'd1);

        // undefined code
        drive(4'b0110, 32'd3, 32'd3, 5'd13);
        tick();
        chk("illegal_result", result, 32'd0);
        chk("illegal_flag", {31'd0, illegal_op}, 32'd1);
        chk("illegal_zero", {31'd0, zero}, 32'd1);
        chk("illegal_valid", {31'd0, out_valid}, 32'd1);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_sel   = 4'($urandom_range(0, 15));
            op_a      = $urandom;
            op_b      = $urandom;
            if ($urandom_range(0, 1) == 1) op_b[4:0] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) op_a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) op_b = op_a;
            rd_in     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
